// File: rtl/bus_xfer_datapath.sv
// ============================================================================
// bus_xfer_datapath: shared-bus register file with a handshaked 3-cycle
// transfer sequencer and ALU/memory side-load paths.
// Optional feature macro: BUS_CONFLICT_TRAP_EN (traps non-one-hot sources).
// Revision: 1.0
// ============================================================================
`default_nettype none

module bus_xfer_datapath #(
  parameter  int DATA_W  = 32,
  parameter  int NUM_GPR = 16,
  localparam int SRC_N   = NUM_GPR + 9,
  localparam int IDX_W   = $clog2(SRC_N)
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                xfer_valid,
  output logic                xfer_ready,
  input  logic [SRC_N-1:0]    src_sel,
  input  logic [SRC_N-1:0]    dst_en,
  output logic                xfer_done,
  output logic [DATA_W-1:0]   bus_contents,
  input  logic                z_load,
  input  logic [2*DATA_W-1:0] z_in,
  input  logic                mem_load,
  input  logic [DATA_W-1:0]   mdata_in,
  input  logic                err_clr,
  output logic                err,
  output logic [15:0]         xfer_count,
  input  logic [IDX_W-1:0]    dbg_idx,
  output logic [DATA_W-1:0]   dbg_data
);

  localparam int I_ZHI = NUM_GPR + 2;
  localparam int I_ZLO = NUM_GPR + 3;
  localparam int I_MDR = NUM_GPR + 6;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRIVE = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [SRC_N-1:0]  src_q, dst_q;
  logic [DATA_W-1:0] bus_q, bus_d;
  logic [DATA_W-1:0] regs_q [SRC_N];
  logic              done_q;
  logic [15:0]       cnt_q;
  logic              err_q;

  logic w_reject, w_latch, w_drive, w_write;

`ifdef BUS_CONFLICT_TRAP_EN
  logic w_onehot;
  assign w_onehot = (src_sel != '0) && ((src_sel & (src_sel - 1'b1)) == '0);
  assign w_reject = (state_q == S_IDLE) && xfer_valid && !w_onehot;
`else
  assign w_reject = 1'b0;
`endif

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (xfer_valid && !w_reject) state_d = S_DRIVE;
      S_DRIVE: state_d = S_WRITE;
      S_WRITE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    xfer_ready = (state_q == S_IDLE);
    w_latch    = (state_q == S_IDLE) && xfer_valid && !w_reject;
    w_drive    = (state_q == S_DRIVE);
    w_write    = (state_q == S_WRITE);
  end

  // Descending scan so the lowest-index set bit is the final winner.
  always_comb begin
    bus_d = '0;
    for (int i = SRC_N - 1; i >= 0; i--) begin
      if (src_q[i]) bus_d = regs_q[i];
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      src_q  <= '0;
      dst_q  <= '0;
      bus_q  <= '0;
      done_q <= 1'b0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      if (w_latch) begin
        src_q <= src_sel;
        dst_q <= dst_en;
      end
      if (w_drive) bus_q <= bus_d;
      done_q <= w_write;
      cnt_q  <= cnt_q + 16'(w_write);
      err_q  <= w_reject | (err_q & ~err_clr);
    end
  end

  // Bus writes take priority over side-loads on the same register.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < SRC_N; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < SRC_N; i++) begin
        if (w_write && dst_q[i])        regs_q[i] <= bus_q;
        else if (z_load && i == I_ZHI)  regs_q[i] <= z_in[2*DATA_W-1:DATA_W];
        else if (z_load && i == I_ZLO)  regs_q[i] <= z_in[DATA_W-1:0];
        else if (mem_load && i == I_MDR) regs_q[i] <= mdata_in;
      end
    end
  end

  always_comb begin
    dbg_data = '0;
    for (int i = 0; i < SRC_N; i++) begin
      if (dbg_idx == IDX_W'(i)) dbg_data = regs_q[i];
    end
  end

  assign xfer_done    = done_q;
  assign bus_contents = bus_q;
  assign xfer_count   = cnt_q;
  assign err          = err_q;

endmodule

`default_nettype wire

// File: tb/tb_bus_xfer_datapath.sv
// ============================================================================
// tb_bus_xfer_datapath: directed scenarios plus randomized traffic checked
// every cycle against a transaction-level model of the datapath.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_bus_xfer_datapath;

  localparam int N    = 25;
  localparam int ZHI  = 18;
  localparam int ZLO  = 19;
  localparam int MDR  = 22;
  localparam int Y    = 24;

  logic          clk = 1'b0;
  logic          clr = 1'b1;
  logic          xfer_valid = 1'b0;
  logic          xfer_ready;
  logic [N-1:0]  src_sel = '0;
  logic [N-1:0]  dst_en = '0;
  logic          xfer_done;
  logic [31:0]   bus_contents;
  logic          z_load = 1'b0;
  logic [63:0]   z_in = '0;
  logic          mem_load = 1'b0;
  logic [31:0]   mdata_in = '0;
  logic          err_clr = 1'b0;
  logic          err;
  logic [15:0]   xfer_count;
  logic [4:0]    dbg_idx = '0;
  logic [31:0]   dbg_data;

  int n_chk  = 0;
  int n_fail = 0;

  bus_xfer_datapath dut (
    .clk(clk), .clr(clr), .xfer_valid(xfer_valid), .xfer_ready(xfer_ready),
    .src_sel(src_sel), .dst_en(dst_en), .xfer_done(xfer_done),
    .bus_contents(bus_contents), .z_load(z_load), .z_in(z_in),
    .mem_load(mem_load), .mdata_in(mdata_in), .err_clr(err_clr), .err(err),
    .xfer_count(xfer_count), .dbg_idx(dbg_idx), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  logic [31:0] m_reg [N];
  logic [31:0] nr    [N];
  logic [31:0] m_bus  = '0;
  logic [15:0] m_cnt  = '0;
  logic        m_err  = 1'b0;
  logic        m_done = 1'b0;
  bit          m_busy = 1'b0;
  int          m_age  = 0;
  logic [N-1:0] m_src = '0, m_dst = '0;

  function automatic logic [31:0] srcval(input logic [N-1:0] s);
    for (int i = 0; i < N; i++) if (s[i]) return m_reg[i];
    return 32'h0;
  endfunction

  always @(posedge clk) begin
    bit acc, bad;
    if (clr) begin
      for (int i = 0; i < N; i++) m_reg[i] = '0;
      m_bus = '0; m_cnt = '0; m_err = 0; m_done = 0; m_busy = 0; m_age = 0;
    end else begin
      nr = m_reg;
      acc = !m_busy && xfer_valid;
`ifdef BUS_CONFLICT_TRAP_EN
      bad = ($countones(src_sel) != 1);
`else
      bad = 1'b0;
`endif
      m_done = 0;
      if (z_load) begin nr[ZHI] = z_in[63:32]; nr[ZLO] = z_in[31:0]; end
      if (mem_load) nr[MDR] = mdata_in;
      if (m_busy) begin
        m_age++;
        if (m_age == 1) m_bus = srcval(m_src);
        else begin
          for (int i = 0; i < N; i++) if (m_dst[i]) nr[i] = m_bus;
          m_done = 1; m_cnt++; m_busy = 0;
        end
      end
      if (err_clr) m_err = 0;
      if (acc) begin
        if (bad) m_err = 1;
        else begin m_busy = 1; m_age = 0; m_src = src_sel; m_dst = dst_en; end
      end
      m_reg = nr;
    end
  end

  always @(posedge clk) begin
    logic [31:0] exp_dbg;
    #2;
    chk("ready", xfer_ready, !m_busy);
    chk("done",  xfer_done,  m_done);
    chk("bus",   bus_contents, m_bus);
    chk("count", xfer_count, m_cnt);
    chk("err",   err, m_err);
    exp_dbg = 32'h0;
    if (int'(dbg_idx) < N) exp_dbg = m_reg[dbg_idx];
    chk("dbg", dbg_data, exp_dbg);
  end

  // ---------------- directed helpers ----------------
  task automatic dbg_chk(input string nm, input int idx, input logic [31:0] exp);
    dbg_idx = 5'(idx);
    #1;
    chk(nm, dbg_data, exp);
  endtask

  // Called at a negedge with the sequencer idle; returns at the negedge after E2.
  task automatic do_xfer(input logic [N-1:0] s, input logic [N-1:0] d, input bit coll);
    xfer_valid = 1; src_sel = s; dst_en = d;
    @(negedge clk);
    xfer_valid = 0;
    @(posedge clk); #2;
    chk("done_e1", xfer_done, 1'b0);
    @(negedge clk);
    if (coll) begin mem_load = 1; mdata_in = 32'h1111_1111; end
    @(posedge clk); #2;
    chk("done_e2", xfer_done, 1'b1);
    @(negedge clk);
    mem_load = 0;
  endtask

  task automatic set_gpr(input int g, input logic [31:0] v);
    mem_load = 1; mdata_in = v;
    @(negedge clk);
    mem_load = 0;
    do_xfer(N'(1) << MDR, N'(1) << g, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    clr = 0;
    #1;
    chk("rst_ready", xfer_ready, 1'b1);
    chk("rst_done",  xfer_done, 1'b0);
    chk("rst_bus",   bus_contents, 32'h0);
    chk("rst_count", xfer_count, 16'h0);
    chk("rst_err",   err, 1'b0);
    dbg_chk("rst_dbg", 0, 32'h0);
    @(negedge clk);

    // broadcast from ZLO
    z_load = 1; z_in = 64'h0000_0001_DEAD_BEEF;
    @(negedge clk);
    z_load = 0;
    do_xfer(N'(1) << ZLO, (N'(1) << 3) | (N'(1) << Y), 0);
    dbg_chk("bc_gpr3", 3, 32'hDEAD_BEEF);
    dbg_chk("bc_y", Y, 32'hDEAD_BEEF);
    dbg_chk("bc_zhi", ZHI, 32'h1);
    chk("bc_count", xfer_count, 16'd1);

    // self-transfer reads the old value
    set_gpr(1, 32'd5);
    do_xfer(N'(1) << 1, (N'(1) << 1) | (N'(1) << 2), 0);
    dbg_chk("self_g1", 1, 32'd5);
    dbg_chk("self_g2", 2, 32'd5);

    // bus write to MDR beats a simultaneous mem_load
    set_gpr(5, 32'h2222_2222);
    do_xfer(N'(1) << 5, N'(1) << MDR, 1);
    dbg_chk("coll_mdr", MDR, 32'h2222_2222);
    chk("coll_count", xfer_count, 16'd5);

    // back-to-back requests with valid held high
    xfer_valid = 1; src_sel = N'(1) << 3; dst_en = N'(1) << 7;
    for (int k = 0; k < 9; k++) begin
      #1;
      chk("hs_ready", xfer_ready, (k % 3) == 0);
      @(negedge clk);
    end
    xfer_valid = 0;
    chk("hs_count", xfer_count, 16'd8);
    dbg_chk("hs_g7", 7, 32'hDEAD_BEEF);

    // multi-hot source
    set_gpr(0, 32'd7);
    set_gpr(1, 32'd9);
    xfer_valid = 1; src_sel = N'(3); dst_en = N'(1) << 4;
`ifdef BUS_CONFLICT_TRAP_EN
    @(negedge clk);
    xfer_valid = 0;
    chk("bad_err", err, 1'b1);
    chk("bad_ready", xfer_ready, 1'b1);
    repeat (3) @(negedge clk);
    dbg_chk("bad_g4", 4, 32'h0);
    chk("bad_count", xfer_count, 16'd10);
    err_clr = 1;
    @(negedge clk);
    err_clr = 0;
    chk("bad_errclr", err, 1'b0);
`else
    xfer_valid = 0;
    do_xfer(N'(3), N'(1) << 4, 0);
    dbg_chk("bad_g4", 4, 32'd7);
    chk("bad_count", xfer_count, 16'd11);
`endif

    // reset during WRITE
    xfer_valid = 1; src_sel = N'(1) << Y; dst_en = N'(1) << 6;
    @(negedge clk);
    xfer_valid = 0;
    @(negedge clk);
    clr = 1;
    #1;
    chk("abort_ready", xfer_ready, 1'b1);
    chk("abort_done", xfer_done, 1'b0);
    @(negedge clk);
    clr = 0;
    @(negedge clk);
    chk("abort_done2", xfer_done, 1'b0);
    chk("abort_count", xfer_count, 16'd0);
    dbg_chk("abort_g6", 6, 32'h0);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      int r;
      xfer_valid = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 9);
      if (r < 8)       src_sel = N'(1) << $urandom_range(0, N - 1);
      else if (r == 8) src_sel = '0;
      else             src_sel = N'($urandom());
      dst_en   = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom());
      z_load   = ($urandom_range(0, 3) == 0);
      z_in     = {$urandom(), $urandom()};
      mem_load = ($urandom_range(0, 3) == 0);
      mdata_in = $urandom();
      err_clr  = ($urandom_range(0, 7) == 0);
      dbg_idx  = 5'($urandom_range(0, 31));
      clr      = ($urandom_range(0, 499) == 0);
      @(negedge clk);
    end
    xfer_valid = 0; z_load = 0; mem_load = 0; err_clr = 0; clr = 0;
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
